// File: rtl/pe_conv_ctrl_pkg.sv
// Shared widths, FSM encoding and 3x3 tap decode for the PE convolution sequencer.
// Pure definitions: no latency, no backpressure.
package pe_conv_ctrl_pkg;

    localparam int BIT_W       = 8;
    localparam int PE_IMAGE_W  = 144;
    localparam int PE_KERNEL_W = 144;
    localparam int PE_BIAS_W   = 13;
    localparam int PE_OUT_W    = 21;
    localparam int ACC_W       = 22;
    localparam int N_TAPS      = 18;
    localparam int TAP_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_K_DRAIN = 3'd2,
        ST_FETCH   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_CALC    = 3'd5,
        ST_OUT     = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    typedef struct packed {
        logic              ch;
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } tap_t;

    // Tap k = ch*9 + row*3 + col maps to a channel and a (-1..1, -1..1) offset.
    function automatic tap_t tap_decode(input logic [TAP_W-1:0] k);
        tap_t             t;
        logic [TAP_W-1:0] rem;
        t.ch = (k >= TAP_W'(9));
        rem  = t.ch ? (k - TAP_W'(9)) : k;
        case (rem)
            5'd0, 5'd1, 5'd2: t.dr = -2'sd1;
            5'd3, 5'd4, 5'd5: t.dr = 2'sd0;
            default:          t.dr = 2'sd1;
        endcase
        case (rem)
            5'd0, 5'd3, 5'd6: t.dc = -2'sd1;
            5'd1, 5'd4, 5'd7: t.dc = 2'sd0;
            default:          t.dc = 2'sd1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pe_requant.sv
// Bias add, round half-up by ROUND_SH, saturate the PE sum to int8.
// Combinational, zero latency; no flow control.
module pe_requant
    import pe_conv_ctrl_pkg::*;
#(
    parameter int ROUND_SH = 4
) (
    input  logic signed [PE_OUT_W-1:0]  i_sum,
    input  logic signed [PE_BIAS_W-1:0] i_bias,
    output logic signed [BIT_W-1:0]     o_data
);

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'((1 << ROUND_SH) >> 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = 22'sd127;
    localparam logic signed [ACC_W-1:0] SAT_LO = -22'sd128;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] y;

    always_comb begin
        acc = ACC_W'(i_sum) + ACC_W'(i_bias);
        y   = (acc + RND) >>> ROUND_SH;
        if (y > SAT_HI) begin
            o_data = 8'sh7f;
        end else if (y < SAT_LO) begin
            o_data = 8'sh80;
        end else begin
            o_data = y[BIT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_conv_ctrl.sv
// Streams 3x3 2-channel convolution outputs from SRAM through an external PE.
// 21 cycles/pixel, first output 40 cycles after start; stalls in OUT while !i_out_ready.
module pe_conv_ctrl
    import pe_conv_ctrl_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int ADDR_W   = 12,
    parameter int IMG_BASE = 0,
    parameter int KER_BASE = 128,
    parameter int ROUND_SH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic signed [PE_BIAS_W-1:0]   i_bias,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_mem_rd,
    output logic [ADDR_W-1:0]             o_mem_addr,
    input  logic [BIT_W-1:0]              i_mem_rdata,
    output logic [PE_IMAGE_W-1:0]         o_pe_image,
    output logic [PE_KERNEL_W-1:0]        o_pe_kernel,
    input  logic signed [PE_OUT_W-1:0]    i_pe_result,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic signed [BIT_W-1:0]       o_out_data,
    output logic [ADDR_W-1:0]             o_out_idx
);

    localparam int CW = ADDR_W + 2;

    state_t                      state_q, state_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic [ADDR_W-1:0]           row_q, row_d;
    logic [ADDR_W-1:0]           col_q, col_d;
    logic [ADDR_W-1:0]           pix_q, pix_d;
    logic signed [PE_BIAS_W-1:0] bias_q, bias_d;
    logic [PE_IMAGE_W-1:0]       img_q, img_d;
    logic [PE_KERNEL_W-1:0]      ker_q, ker_d;
    logic                        wr_en_q, wr_en_d;
    logic                        wr_ker_q, wr_ker_d;
    logic                        wr_pad_q, wr_pad_d;
    logic [TAP_W-1:0]            wr_slot_q, wr_slot_d;
    logic [BIT_W-1:0]            out_dat_q, out_dat_d;
    logic [ADDR_W-1:0]           out_idx_q, out_idx_d;

    tap_t                        td;
    logic signed [CW-1:0]        tap_r, tap_c;
    logic [ADDR_W-1:0]           tap_lin;
    logic                        tap_pad;
    logic [ADDR_W-1:0]           img_addr;
    logic                        rd_en;
    logic [ADDR_W-1:0]           rd_addr;
    logic signed [BIT_W-1:0]     req_dat;

    pe_requant #(
        .ROUND_SH (ROUND_SH)
    ) u_requant (
        .i_sum  (i_pe_result),
        .i_bias (bias_q),
        .o_data (req_dat)
    );

    // Window tap position relative to the current output pixel, with pad detection.
    always_comb begin
        td       = tap_decode(tap_q);
        tap_r    = $signed({2'b00, row_q}) + CW'($signed(td.dr));
        tap_c    = $signed({2'b00, col_q}) + CW'($signed(td.dc));
        tap_pad  = tap_r[CW-1] || tap_c[CW-1] ||
                   (tap_r >= CW'(IMG_H)) || (tap_c >= CW'(IMG_W));
        tap_lin  = tap_r[ADDR_W-1:0] * ADDR_W'(IMG_W) + tap_c[ADDR_W-1:0];
        img_addr = ADDR_W'(IMG_BASE) + (td.ch ? ADDR_W'(IMG_H * IMG_W) : '0) + tap_lin;
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        row_d     = row_q;
        col_d     = col_q;
        pix_d     = pix_q;
        bias_d    = bias_q;
        wr_en_d   = 1'b0;
        wr_ker_d  = 1'b0;
        wr_pad_d  = 1'b0;
        wr_slot_d = tap_q;
        out_dat_d = out_dat_q;
        out_idx_d = out_idx_q;
        rd_en     = 1'b0;
        rd_addr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    bias_d  = i_bias;
                    tap_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    pix_d   = '0;
                    state_d = ST_LOAD_K;
                end
            end
            ST_LOAD_K: begin
                rd_en    = 1'b1;
                rd_addr  = ADDR_W'(KER_BASE) + ADDR_W'(tap_q);
                wr_en_d  = 1'b1;
                wr_ker_d = 1'b1;
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ST_K_DRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_K_DRAIN: state_d = ST_FETCH;
            ST_FETCH: begin
                // Padded taps skip the read; the slot is still written (with zero) next cycle.
                rd_en    = !tap_pad;
                rd_addr  = tap_pad ? '0 : img_addr;
                wr_en_d  = 1'b1;
                wr_pad_d = tap_pad;
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_CALC;
            ST_CALC: begin
                out_dat_d = req_dat;
                out_idx_d = pix_q;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    if (pix_q == ADDR_W'(IMG_W * IMG_H - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        pix_d = pix_q + 1'b1;
                        if (col_q == ADDR_W'(IMG_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data lands one cycle after issue into the slot recorded at issue time.
    always_comb begin
        img_d = img_q;
        ker_d = ker_q;
        for (int k = 0; k < N_TAPS; k++) begin
            if (wr_en_q && (wr_slot_q == TAP_W'(k))) begin
                if (wr_ker_q) begin
                    ker_d[PE_KERNEL_W-1-8*k -: 8] = i_mem_rdata;
                end else begin
                    img_d[PE_IMAGE_W-1-8*k -: 8] = wr_pad_q ? '0 : i_mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pix_q     <= '0;
            bias_q    <= '0;
            img_q     <= '0;
            ker_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_ker_q  <= 1'b0;
            wr_pad_q  <= 1'b0;
            wr_slot_q <= '0;
            out_dat_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pix_q     <= pix_d;
            bias_q    <= bias_d;
            img_q     <= img_d;
            ker_q     <= ker_d;
            wr_en_q   <= wr_en_d;
            wr_ker_q  <= wr_ker_d;
            wr_pad_q  <= wr_pad_d;
            wr_slot_q <= wr_slot_d;
            out_dat_q <= out_dat_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_mem_rd    = rd_en;
    assign o_mem_addr  = rd_addr;
    assign o_pe_image  = img_q;
    assign o_pe_kernel = ker_q;
    assign o_out_valid = (state_q == ST_OUT);
    assign o_out_data  = out_dat_q;
    assign o_out_idx   = out_idx_q;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl on a 4x4 image: SRAM + PE models, reference convolution scoreboard.
module tb_pe_conv_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 12;
    localparam int KB   = 128;
    localparam int NPIX = W * H;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [12:0] bias;
    logic               busy, done, mem_rd;
    logic [AW-1:0]      mem_addr;
    logic [7:0]         mem_rdata;
    logic [143:0]       pe_image, pe_kernel;
    logic signed [20:0] pe_result;
    logic               out_valid, out_ready;
    logic signed [7:0]  out_data;
    logic [AW-1:0]      out_idx;

    always #5 clk = ~clk;

    pe_conv_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .IMG_BASE(0), .KER_BASE(KB), .ROUND_SH(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bias(bias),
        .o_busy(busy), .o_done(done), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .i_mem_rdata(mem_rdata), .o_pe_image(pe_image), .o_pe_kernel(pe_kernel),
        .i_pe_result(pe_result), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_idx(out_idx)
    );

    logic [7:0] mem [0:4095];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < 18; k++) begin
            s += int'($signed(pe_image[143-8*k -: 8])) * int'($signed(pe_kernel[143-8*k -: 8]));
        end
        pe_result = 21'(s);
    end

    typedef struct { int idx; int dat; } exp_t;
    typedef struct {
        int img_mode; int img_val; int ker_mode; int ker_val; int bias;
        int exp_c; int exp_e; int exp_i;
    } vec_t;

    exp_t sb_q[$];
    int   hs_cyc[$];
    int   got_dat [0:NPIX-1];
    vec_t vecs [0:5];
    int   total = 0, bad = 0;
    int   cyc = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: read-address sanity, done pulses, output handshakes against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_cnt++;
                check("rd_addr_range", int'((mem_addr < 12'd32) ||
                      (mem_addr >= 12'(KB) && mem_addr < 12'(KB + 18))), 1);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (int'(out_idx) < NPIX) got_dat[out_idx] = int'(out_data);
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_idx", int'(out_idx), e.idx);
                    check("out_data", int'(out_data), e.dat);
                end
            end
        end
    end

    task automatic setup(input vec_t v);
        for (int a = 0; a < NPIX; a++) begin
            mem[a]        = (v.img_mode == 0) ? 8'(a) : 8'(v.img_val);
            mem[NPIX + a] = (v.img_mode == 0) ? 8'h00 : 8'(v.img_val);
        end
        for (int k = 0; k < 18; k++) begin
            case (v.ker_mode)
                0:       mem[KB + k] = (k == 4) ? 8'(v.ker_val) : 8'h00;
                1:       mem[KB + k] = (k < 9) ? 8'(v.ker_val) : 8'h00;
                default: mem[KB + k] = 8'(v.ker_val);
            endcase
        end
    endtask

    function automatic int ref_pix(input int r, input int x, input int b);
        int s, y;
        s = 0;
        for (int c = 0; c < 2; c++)
            for (int dr = -1; dr <= 1; dr++)
                for (int dx = -1; dx <= 1; dx++)
                    if (r + dr >= 0 && r + dr < H && x + dx >= 0 && x + dx < W)
                        s += int'($signed(mem[c*NPIX + (r+dr)*W + (x+dx)])) *
                             int'($signed(mem[KB + c*9 + (dr+1)*3 + (dx+1)]));
        y = (s + b + 8) >>> 4;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_mem_rd"}, int'(mem_rd), 0);
        check({tag, "_mem_addr"}, int'(mem_addr), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_idx"}, int'(out_idx), 0);
        check({tag, "_pe_image_zero"}, int'(pe_image == '0), 1);
        check({tag, "_pe_kernel_zero"}, int'(pe_kernel == '0), 1);
    endtask

    // Issues start with bias b, checks latency, pokes a start while busy, returns at first valid.
    task automatic kick(input int b);
        int  lat;
        bit  seen;
        for (int p = 0; p < NPIX; p++) sb_q.push_back('{p, ref_pix(p / W, p % W, b)});
        hs_cyc.delete();
        @(posedge clk); #1 start = 1'b1; bias = 13'(b);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk); lat++;
            if (lat == 1) begin #1 start = 1'b0; bias = ~bias; end
            @(negedge clk); seen = out_valid;
        end
        check("first_out_latency", lat, 40);
        @(posedge clk); #1 start = 1'b1; bias = 13'sd2000;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_case(input int b, input bit bp);
        int rd0, hs0, dn0, n, d0, i0;
        bit seen;
        rd0 = rd_cnt; hs0 = hs_cnt; dn0 = done_cnt;
        kick(b);
        if (bp) begin
            seen = 1'b0; n = 0;
            while (!seen && n < 1000) begin
                @(negedge clk); n++; seen = out_valid && out_idx == 5;
            end
            check("bp_reach_pixel5", int'(seen), 1);
            @(posedge clk); #1 out_ready = 1'b0;
            seen = 1'b0; n = 0;
            while (!seen && n < 100) begin
                @(negedge clk); n++; seen = out_valid;
            end
            d0 = int'(out_data); i0 = int'(out_idx);
            check("bp_stalled_idx", i0, 6);
            repeat (5) begin
                @(negedge clk);
                check("bp_valid_held", int'(out_valid), 1);
                check("bp_data_stable", int'(out_data), d0);
                check("bp_idx_stable", int'(out_idx), i0);
                check("bp_no_mem_rd", int'(mem_rd), 0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
        end
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check("run_completes", int'(busy), 0);
        check("done_pulses", done_cnt - dn0, 1);
        check("handshakes", hs_cnt - hs0, NPIX);
        check("sram_reads", rd_cnt - rd0, 218);
        check("sb_drained", sb_q.size(), 0);
        check("pixel_interval", (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1, 21);
    endtask

    initial begin
        int n;
        bit seen;
        int dn0;
        rst_n = 1'b0; start = 1'b0; bias = '0; out_ready = 1'b1;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

        vecs[0] = '{0, 0,    0, 16,  0,  0,    1,    5};
        vecs[1] = '{1, 1,    1, 16,  0,  4,    6,    9};
        vecs[2] = '{1, 127,  2, 127, 0,  127,  127,  127};
        vecs[3] = '{1, -128, 2, 127, 0,  -128, -128, -128};
        vecs[4] = '{1, 0,    0, 16,  8,  1,    1,    1};
        vecs[5] = '{1, 0,    0, 16, -9, -1,   -1,   -1};

        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            setup(vecs[i]);
            run_case(vecs[i].bias, 1'b0);
            check($sformatf("vec%0d_corner", i), got_dat[0], vecs[i].exp_c);
            check($sformatf("vec%0d_edge", i), got_dat[1], vecs[i].exp_e);
            check($sformatf("vec%0d_interior", i), got_dat[5], vecs[i].exp_i);
        end

        setup(vecs[1]);
        run_case(0, 1'b1);

        // Abort a run at pixel 7 with reset, then a clean restart.
        setup(vecs[0]);
        dn0 = done_cnt;
        kick(0);
        seen = 1'b0; n = 0;
        while (!seen && n < 1000) begin
            @(negedge clk); n++; seen = out_valid && out_idx == 7;
        end
        check("rst_reach_pixel7", int'(seen), 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        repeat (3) begin @(negedge clk); chk_zero("midrun_reset_hold"); end
        rst_n = 1'b1;
        check("no_done_after_abort", done_cnt - dn0, 0);
        sb_q.delete();
        run_case(0, 1'b0);
        for (int p = 0; p < NPIX; p++) check("restart_identity", got_dat[p], p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
